// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_pkg
// Brief    : Shared state, op and counter definitions for the memory responder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam int LAT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
//------------------------------------------------------------------------------
// Module   : mem_array
// Brief    : Word array with synchronous write and registered read.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_array #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Read register only loads on re, so it holds across writes and idle time.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
      if (re) begin
         r_rdata <= r_mem[addr];
      end
   end

   assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// Module   : mem_responder
// Brief    : Latency-modelling single-request memory responder with ready/busy.
//            MEM_BOUNDS_CHECK_EN rejects addresses >= DEPTH; otherwise wraps.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic                  busy,
   output logic                  err
);

   localparam logic [LAT_CNT_W-1:0] c_lat_init = LAT_CNT_W'(LATENCY - 1);
   localparam logic [ADDR_WIDTH:0]  c_depth    = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [LAT_CNT_W-1:0]    r_cnt;
   logic                    r_op;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic                    r_err;
   logic                    r_rd_valid;

   logic                    w_start;
   logic                    w_err_nxt;
   logic                    w_access;
   logic                    w_we;
   logic                    w_re;
   logic                    w_oob;
   logic [ADDR_WIDTH-1:0]   w_addr_map;
   logic [DATA_WIDTH-1:0]   w_arr_rdata;

`ifdef MEM_BOUNDS_CHECK_EN
   assign w_oob      = ({1'b0, addr} >= c_depth);
   assign w_addr_map = addr;
`else
   logic [ADDR_WIDTH:0] w_addr_ext;
   assign w_oob      = 1'b0;
   assign w_addr_ext = {1'b0, addr} % c_depth;
   assign w_addr_map = w_addr_ext[ADDR_WIDTH-1:0];
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_read && mem_write) begin
               w_err_nxt = 1'b1;
            end else if (mem_read || mem_write) begin
               if (w_oob) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_start     = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Gating with reset keeps an aborted request from touching the array.
   assign w_access = (r_state == S_WAIT) && (r_cnt == '0) && !reset;
   assign w_we     = w_access && (r_op == OP_WRITE);
   assign w_re     = w_access && (r_op == OP_READ);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_op       <= OP_READ;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_err_nxt;
         if (w_start) begin
            r_cnt   <= c_lat_init;
            r_op    <= mem_write ? OP_WRITE : OP_READ;
            r_addr  <= w_addr_map;
            r_wdata <= wdata;
         end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_re) begin
            r_rd_valid <= 1'b1;
         end
      end
   end

   mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem_array (
      .clk   (clk),
      .we    (w_we),
      .re    (w_re),
      .addr  (r_addr),
      .wdata (r_wdata),
      .rdata (w_arr_rdata)
   );

   // The array's read register has no reset; mask it until a read has landed.
   assign rdata = r_rd_valid ? w_arr_rdata : '0;
   assign ready = (r_state == S_DONE);
   assign busy  = (r_state != S_IDLE);
   assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_responder
// Brief    : Scoreboard bench for mem_responder (DEPTH=200, LATENCY=2).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int DEP = 200;
   localparam int LAT = 2;

   typedef struct {
      bit          is_err;
      int          cyc;
      logic [31:0] rdata;
   } item_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mem_read = 1'b0;
   logic          mem_write = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          ready;
   logic          busy;
   logic          err;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   bit          in_rst = 1'b1;
   item_t       exp_q[$];
   item_t       mon_it;
   logic [31:0] mon_rdata = '0;
   logic [31:0] exp_rdata_track = '0;
   logic [31:0] mdl_mem [0:DEP-1];

   mem_responder #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEP),
      .LATENCY    (LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Word index a request lands on, or -1 when it must be rejected.
   function automatic int map_addr(int a);
`ifdef MEM_BOUNDS_CHECK_EN
      return (a >= DEP) ? -1 : a;
`else
      return a % DEP;
`endif
   endfunction

   always @(negedge clk) begin
      if (!in_rst) begin
         if (ready || err) begin
            if (exp_q.size() == 0) begin
               chk("spurious_resp", {30'b0, ready, err}, 32'h0);
            end else begin
               mon_it = exp_q.pop_front();
               chk("resp_both", {31'b0, ready & err}, 32'h0);
               chk("resp_kind_err", {31'b0, err}, {31'b0, mon_it.is_err});
               chk("resp_cycle", 32'(cyc), 32'(mon_it.cyc));
               if (!mon_it.is_err) mon_rdata = mon_it.rdata;
            end
         end
         chk("rdata", rdata, mon_rdata);
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("resp_timeout", 32'(exp_q.size()), 32'h0);
         exp_q.delete();
      end
   endtask

   // Called just after a posedge with the DUT idle.
   task automatic do_req(input bit rd, input bit wr, input int a,
                         input logic [31:0] d, input bit glitch);
      item_t it;
      int    m;
      m = map_addr(a);
      mem_read  = rd;
      mem_write = wr;
      addr      = AW'(a);
      wdata     = d;
      if (rd && wr || ((rd || wr) && m < 0)) begin
         it.is_err = 1'b1;
         it.cyc    = cyc + 1;
         it.rdata  = '0;
         exp_q.push_back(it);
         @(posedge clk); #1;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         @(negedge clk);
         chk("busy_on_err", {31'b0, busy}, 32'h0);
         @(posedge clk); #1;
      end else if (rd || wr) begin
         if (wr) mdl_mem[m] = d;
         else    exp_rdata_track = mdl_mem[m];
         it.is_err = 1'b0;
         it.cyc    = cyc + LAT + 1;
         it.rdata  = exp_rdata_track;
         exp_q.push_back(it);
         @(posedge clk); #1;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         if (glitch) begin
            addr      = AW'($urandom_range(0, 255));
            wdata     = $urandom;
            mem_write = 1'b1;
         end
         @(negedge clk);
         chk("busy_in_flight", {31'b0, busy}, 32'h1);
         @(posedge clk); #1;
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
      wait_drain();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      in_rst = 1'b0;
      @(negedge clk);
      chk("rst_busy",  {31'b0, busy},  32'h0);
      chk("rst_ready", {31'b0, ready}, 32'h0);
      chk("rst_err",   {31'b0, err},   32'h0);
      @(posedge clk); #1;

      for (int i = 0; i < DEP; i++) do_req(1'b0, 1'b1, i, $urandom, 1'b0);

      do_req(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0);
      do_req(1'b1, 1'b0, 8'h05, 32'h0, 1'b0);
      idle(5);
      do_req(1'b0, 1'b1, 8'h06, 32'h12345678, 1'b0);
      idle(2);
      do_req(1'b1, 1'b1, 8'h05, 32'hFFFF0000, 1'b0);
      do_req(1'b1, 1'b0, 8'h05, 32'h0, 1'b0);
      do_req(1'b0, 1'b1, 8'h20, 32'hA5A5A5A5, 1'b1);
      do_req(1'b1, 1'b0, 8'h20, 32'h0, 1'b0);
      do_req(1'b1, 1'b0, 8'hF0, 32'h0, 1'b0);

      // Reset during the final wait cycle of a write must discard it.
      do_req(1'b0, 1'b1, 8'h10, 32'h1, 1'b0);
      mem_write = 1'b1;
      addr      = 8'h10;
      wdata     = 32'hBAD0BAD0;
      @(posedge clk); #1;
      mem_write = 1'b0;
      @(posedge clk); #1;
      reset  = 1'b1;
      in_rst = 1'b1;
      @(posedge clk); #1;
      reset           = 1'b0;
      mon_rdata       = '0;
      exp_rdata_track = '0;
      in_rst          = 1'b0;
      @(negedge clk);
      chk("abort_ready", {31'b0, ready}, 32'h0);
      chk("abort_busy",  {31'b0, busy},  32'h0);
      chk("abort_err",   {31'b0, err},   32'h0);
      @(posedge clk); #1;
      do_req(1'b1, 1'b0, 8'h10, 32'h0, 1'b0);

      for (int i = 0; i < 200; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 4)      do_req(1'b0, 1'b1, $urandom_range(0, 255), $urandom, $urandom_range(0, 3) == 0);
         else if (r < 8) do_req(1'b1, 1'b0, $urandom_range(0, 255), 32'h0, $urandom_range(0, 3) == 0);
         else if (r < 9) do_req(1'b1, 1'b1, $urandom_range(0, 255), $urandom, 1'b0);
         else            idle($urandom_range(1, 3));
      end

      idle(4);
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
